dsp_pipe_reg: RTL and testbench

- Parametrised successor to the single-stage DSP48A1 operand/result registers (A/B/C/D/M/P).
- Provides a DEPTH-stage delay line of WIDTH bits, with a valid bit travelling alongside the data.
- Shared clock enable, synchronous flush and in-flight occupancy count.
- DEPTH=0 gives a combinational bypass, so one block replaces every xREG=0/1 register instance and deeper pipelining stays available for timing closure.

---
 rtl/dsp_pkg.sv | 39 +++
 rtl/dsp_pipe_reg_if.sv | 33 +++
 rtl/dsp_pipe_stage.sv | 57 +++++
 rtl/dsp_pipe_reg.sv | 102 ++++++++++
 tb/tb_dsp_pipe_reg.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP pipeline definitions: reset-type encodings for the legacy
// register wrappers, the maximum pipeline depth and small helper functions
// used to size and count the occupancy of the pipeline.
package dsp_pkg;

    typedef enum logic {
        SYNC  = 1'b0,
        ASYNC = 1'b1
    } rst_type_e;

    localparam int MAX_PIPE_DEPTH = 8;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of the occupancy counter; never narrower than one bit.
    function automatic int pendWidth(input int depth);
        return (depth == 0) ? 1 : clog2(depth + 1);
    endfunction

    function automatic int popcount(input logic [MAX_PIPE_DEPTH-1:0] bits);
        int count;
        count = 0;
        for (int i = 0; i < MAX_PIPE_DEPTH; i++) begin
            count = count + int'(bits[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/dsp_pipe_reg_if.sv
// Data/valid/control bundle of the DSP pipeline register.
// With PIPE_PARITY_EN defined the bundle also carries the sticky PERR flag.
interface dsp_pipe_reg_if #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 1
);
    import dsp_pkg::*;

    localparam int PW = pendWidth(DEPTH);

    logic             CE;
    logic             FLUSH;
    logic [WIDTH-1:0] D;
    logic             D_VALID;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic [PW-1:0]    PEND;
    logic             BUSY;
`ifdef PIPE_PARITY_EN
    logic             PERR;

    modport master (output CE, FLUSH, D, D_VALID,
                    input  Q, Q_VALID, PEND, BUSY, PERR);
    modport slave  (input  CE, FLUSH, D, D_VALID,
                    output Q, Q_VALID, PEND, BUSY, PERR);
`else
    modport master (output CE, FLUSH, D, D_VALID,
                    input  Q, Q_VALID, PEND, BUSY);
    modport slave  (input  CE, FLUSH, D, D_VALID,
                    output Q, Q_VALID, PEND, BUSY);
`endif

endinterface

// File: rtl/dsp_pipe_stage.sv
// One register stage of the DSP pipeline: data word plus its valid bit.
// With PIPE_PARITY_EN defined the stage also carries an even-parity bit.
module dsp_pipe_stage #(
    parameter int               WIDTH  = 48,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
`ifdef PIPE_PARITY_EN
    input  logic             D_PAR,
    output logic             Q_PAR,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
`ifdef PIPE_PARITY_EN
    localparam logic RSTPAR = ^RSTVAL;
    logic             r_par;
`endif

    // Reset and flush return the stage to an empty bubble; CE advances it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data  <= RSTVAL;
            r_valid <= 1'b0;
`ifdef PIPE_PARITY_EN
            r_par   <= RSTPAR;
`endif
        end else if (FLUSH) begin
            r_data  <= RSTVAL;
            r_valid <= 1'b0;
`ifdef PIPE_PARITY_EN
            r_par   <= RSTPAR;
`endif
        end else if (CE) begin
            r_data  <= D;
            r_valid <= D_VALID;
`ifdef PIPE_PARITY_EN
            r_par   <= D_PAR;
`endif
        end
    end

    assign Q       = r_data;
    assign Q_VALID = r_valid;
`ifdef PIPE_PARITY_EN
    assign Q_PAR   = r_par;
`endif

endmodule

// File: rtl/dsp_pipe_reg.sv
// DEPTH-stage DSP delay line with travelling valid bit, shared clock enable,
// synchronous flush and registered occupancy count. DEPTH=0 is a pure wire.
// Optional PIPE_PARITY_EN adds per-stage parity and a sticky PERR output.
module dsp_pipe_reg
    import dsp_pkg::*;
#(
    parameter int               WIDTH  = 48,
    parameter int               DEPTH  = 1,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input logic           CLK,
    input logic           RST,
    dsp_pipe_reg_if.slave bus
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;

            assign bus.Q       = bus.D;
            assign bus.Q_VALID = bus.D_VALID;
            assign bus.PEND    = '0;
            assign bus.BUSY    = 1'b0;
`ifdef PIPE_PARITY_EN
            assign bus.PERR    = 1'b0;
`endif
            assign w_unused = &{1'b0, CLK, RST, bus.CE, bus.FLUSH, RSTVAL};
        end else begin : g_pipe
            localparam int PW = pendWidth(DEPTH);

            logic [WIDTH-1:0]          w_data [0:DEPTH];
            logic [DEPTH:0]            w_valid;
            logic [MAX_PIPE_DEPTH-1:0] w_validNext;
            logic [PW-1:0]             r_pend;
`ifdef PIPE_PARITY_EN
            logic [DEPTH:0]            w_par;
            logic                      r_perr;

            assign w_par[0] = ^bus.D;
`endif

            assign w_data[0]  = bus.D;
            assign w_valid[0] = bus.D_VALID;

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                dsp_pipe_stage #(
                    .WIDTH  (WIDTH),
                    .RSTVAL (RSTVAL)
                ) u_stage (
                    .CLK     (CLK),
                    .RST     (RST),
                    .CE      (bus.CE),
                    .FLUSH   (bus.FLUSH),
                    .D       (w_data[i]),
                    .D_VALID (w_valid[i]),
`ifdef PIPE_PARITY_EN
                    .D_PAR   (w_par[i]),
                    .Q_PAR   (w_par[i+1]),
`endif
                    .Q       (w_data[i+1]),
                    .Q_VALID (w_valid[i+1])
                );
            end

            // The valid bits each stage will hold after a CE edge are exactly
            // the valid inputs currently presented to the stages.
            assign w_validNext = MAX_PIPE_DEPTH'(w_valid[DEPTH-1:0]);

            // Occupancy follows the stages on the same edge with the same priority.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_pend <= '0;
                end else if (bus.FLUSH) begin
                    r_pend <= '0;
                end else if (bus.CE) begin
                    r_pend <= PW'(popcount(w_validNext));
                end
            end

`ifdef PIPE_PARITY_EN
            // Sticky error whenever a valid output word disagrees with its parity.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_perr <= 1'b0;
                end else if (bus.FLUSH) begin
                    r_perr <= 1'b0;
                end else if (w_valid[DEPTH] && ((^w_data[DEPTH]) ^ w_par[DEPTH])) begin
                    r_perr <= 1'b1;
                end
            end

            assign bus.PERR = r_perr;
`endif

            assign bus.Q       = w_data[DEPTH];
            assign bus.Q_VALID = w_valid[DEPTH];
            assign bus.PEND    = r_pend;
            assign bus.BUSY    = (r_pend != '0);
        end
    endgenerate

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Self-checking bench for dsp_pipe_reg: five configurations (DEPTH 3/0/2/4/8)
// share one stimulus stream and are compared every cycle against a history
// model ("word accepted k CE edges ago"), plus directed literal checks.
module tb_dsp_pipe_reg;

    localparam int         NI = 5;
    localparam int         DEP  [NI] = '{3, 0, 2, 4, 8};
    localparam logic [63:0] MASK [NI] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0000_FFFF_FFFF_FFFF,
                                          64'h0000_0000_0000_00FF, 64'h0000_0000_0000_FFFF,
                                          64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [63:0] RV   [NI] = '{64'h0, 64'h0, 64'h5A, 64'h0, 64'hDEAD_BEEF_0123_4567};

    logic        clk;
    logic        rst;
    logic        ce;
    logic        flush;
    logic        dv;
    logic [63:0] d;
    bit          chkEn;
    int          tests;
    int          fails;

    // History model: mD[i][k] / mV[i][k] is the word accepted k CE edges ago.
    logic [63:0] mD [NI][9];
    logic        mV [NI][9];

    logic [63:0] aQ [NI];
    logic        aV [NI];
    logic [63:0] aP [NI];
    logic        aB [NI];

    dsp_pipe_reg_if #(.WIDTH(48), .DEPTH(3)) if3 ();
    dsp_pipe_reg_if #(.WIDTH(48), .DEPTH(0)) if0 ();
    dsp_pipe_reg_if #(.WIDTH(8),  .DEPTH(2)) if2 ();
    dsp_pipe_reg_if #(.WIDTH(16), .DEPTH(4)) if4 ();
    dsp_pipe_reg_if #(.WIDTH(64), .DEPTH(8)) if8 ();

    dsp_pipe_reg #(.WIDTH(48), .DEPTH(3), .RSTVAL(48'h0))   u3 (.CLK(clk), .RST(rst), .bus(if3.slave));
    dsp_pipe_reg #(.WIDTH(48), .DEPTH(0), .RSTVAL(48'h0))   u0 (.CLK(clk), .RST(rst), .bus(if0.slave));
    dsp_pipe_reg #(.WIDTH(8),  .DEPTH(2), .RSTVAL(8'h5A))   u2 (.CLK(clk), .RST(rst), .bus(if2.slave));
    dsp_pipe_reg #(.WIDTH(16), .DEPTH(4), .RSTVAL(16'h0))   u4 (.CLK(clk), .RST(rst), .bus(if4.slave));
    dsp_pipe_reg #(.WIDTH(64), .DEPTH(8), .RSTVAL(64'hDEAD_BEEF_0123_4567)) u8 (.CLK(clk), .RST(rst), .bus(if8.slave));

    assign if3.CE = ce;  assign if3.FLUSH = flush;  assign if3.D_VALID = dv;  assign if3.D = d[47:0];
    assign if0.CE = ce;  assign if0.FLUSH = flush;  assign if0.D_VALID = dv;  assign if0.D = d[47:0];
    assign if2.CE = ce;  assign if2.FLUSH = flush;  assign if2.D_VALID = dv;  assign if2.D = d[7:0];
    assign if4.CE = ce;  assign if4.FLUSH = flush;  assign if4.D_VALID = dv;  assign if4.D = d[15:0];
    assign if8.CE = ce;  assign if8.FLUSH = flush;  assign if8.D_VALID = dv;  assign if8.D = d;

    assign aQ[0] = 64'(if3.Q); assign aV[0] = if3.Q_VALID; assign aP[0] = 64'(if3.PEND); assign aB[0] = if3.BUSY;
    assign aQ[1] = 64'(if0.Q); assign aV[1] = if0.Q_VALID; assign aP[1] = 64'(if0.PEND); assign aB[1] = if0.BUSY;
    assign aQ[2] = 64'(if2.Q); assign aV[2] = if2.Q_VALID; assign aP[2] = 64'(if2.PEND); assign aB[2] = if2.BUSY;
    assign aQ[3] = 64'(if4.Q); assign aV[3] = if4.Q_VALID; assign aP[3] = 64'(if4.PEND); assign aB[3] = if4.BUSY;
    assign aQ[4] = 64'(if8.Q); assign aV[4] = if8.Q_VALID; assign aP[4] = 64'(if8.PEND); assign aB[4] = if8.BUSY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 9; k++) begin
                mD[i][k] = RV[i];
                mV[i][k] = 1'b0;
            end
        end
    endtask

    // Model: reset/flush empty every history; a CE edge records the new word.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            modelReset();
        end else if (ce) begin
            for (int i = 0; i < NI; i++) begin
                for (int k = 8; k >= 2; k--) begin
                    mD[i][k] = mD[i][k-1];
                    mV[i][k] = mV[i][k-1];
                end
                mD[i][1] = d & MASK[i];
                mV[i][1] = dv;
            end
        end
    end

    // Compare every configuration against the model away from the clock edge.
    always @(negedge clk) begin
        if (chkEn) begin
            for (int i = 0; i < NI; i++) begin
                logic [63:0] expQ;
                logic        expV;
                int          expP;
                expP = 0;
                if (DEP[i] == 0) begin
                    expQ = d & MASK[i];
                    expV = dv;
                end else begin
                    expQ = mD[i][DEP[i]];
                    expV = mV[i][DEP[i]];
                    for (int k = 1; k <= DEP[i]; k++) expP += int'(mV[i][k]);
                end
                checkOutput($sformatf("depth%0d.Q", DEP[i]), aQ[i], expQ);
                checkOutput($sformatf("depth%0d.Q_VALID", DEP[i]), 64'(aV[i]), 64'(expV));
                checkOutput($sformatf("depth%0d.PEND", DEP[i]), aP[i], 64'(expP));
                checkOutput($sformatf("depth%0d.BUSY", DEP[i]), 64'(aB[i]), 64'(expP != 0));
            end
        end
    end

    task automatic applyStimulus(input logic c, input logic f, input logic v, input logic [63:0] data);
        ce    = c;
        flush = f;
        dv    = v;
        d     = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        chkEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        modelReset();
        #1 rst = 1'b1;
        #1;
        checkOutput("reset.Q", aQ[0], 64'h0);
        checkOutput("reset.Q_VALID", 64'(aV[0]), 64'h0);
        checkOutput("reset.PEND", aP[0], 64'h0);
        checkOutput("reset.Q_depth8", aQ[4], 64'hDEAD_BEEF_0123_4567);
        tick();
        tick();
        rst = 1'b0;

        // Latency and occupancy through DEPTH=3
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h1); tick(); checkOutput("lat.pend1", aP[0], 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h2); tick(); checkOutput("lat.pend2", aP[0], 64'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h3); tick(); checkOutput("lat.pend3", aP[0], 64'd3);
        checkOutput("lat.q1", aQ[0], 64'h1);
        checkOutput("lat.v1", 64'(aV[0]), 64'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0); tick();
        checkOutput("lat.q2", aQ[0], 64'h2); checkOutput("lat.pend4", aP[0], 64'd2);
        tick();
        checkOutput("lat.q3", aQ[0], 64'h3); checkOutput("lat.pend5", aP[0], 64'd1);
        tick();
        checkOutput("lat.v_end", 64'(aV[0]), 64'h0); checkOutput("lat.busy_end", 64'(aB[0]), 64'h0);

        // Reset mid-stream drops everything before any edge
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h7);
        repeat (3) tick();
        checkOutput("mid.q_before", aQ[0], 64'h7);
        rst = 1'b1;
        #1;
        checkOutput("mid.q_rst", aQ[0], 64'h0);
        checkOutput("mid.v_rst", 64'(aV[0]), 64'h0);
        checkOutput("mid.pend_rst", aP[0], 64'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        repeat (3) tick();
        checkOutput("mid.no_stale_valid", 64'(aV[0]), 64'h0);

        // Stall on DEPTH=2
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0); tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'hA5); tick();
        checkOutput("stall.pend", aP[2], 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        for (int n = 0; n < 5; n++) begin
            tick();
            checkOutput("stall.hold_q", aQ[2], 64'h5A);
            checkOutput("stall.hold_pend", aP[2], 64'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0); tick();
        checkOutput("stall.q", aQ[2], 64'hA5);
        checkOutput("stall.v", 64'(aV[2]), 64'h1);
        tick();
        checkOutput("stall.drain", aP[2], 64'd0);

        // Flush priority on DEPTH=4
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h11); tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h22); tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h33); tick();
        checkOutput("flush.pend_before", aP[3], 64'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'hFF); tick();
        checkOutput("flush.pend", aP[3], 64'd0);
        checkOutput("flush.v", 64'(aV[3]), 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        for (int n = 0; n < 6; n++) begin
            tick();
            checkOutput("flush.q_never_ff", aQ[3], 64'h0);
        end

        // Combinational bypass
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC);
        #1;
        checkOutput("bypass.q", aQ[1], 64'h1234_5678_9ABC);
        checkOutput("bypass.v", 64'(aV[1]), 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("bypass.q_rst", aQ[1], 64'h1234_5678_9ABC);
        checkOutput("bypass.pend_rst", aP[1], 64'h0);
        rst = 1'b0;
        tick();
        checkOutput("bypass.q_clk", aQ[1], 64'h1234_5678_9ABC);

`ifdef PIPE_PARITY_EN
        // Corrupt the last stage of DEPTH=2 while it holds a valid word
        chkEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0); tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'hA5); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);  tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("par.clean", 64'(if2.PERR), 64'h0);
        force u2.g_pipe.g_stage[1].u_stage.r_data = 8'hA4;
        tick();
        release u2.g_pipe.g_stage[1].u_stage.r_data;
        checkOutput("par.set", 64'(if2.PERR), 64'h1);
        tick();
        checkOutput("par.sticky", 64'(if2.PERR), 64'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0); tick();
        checkOutput("par.cleared", 64'(if2.PERR), 64'h0);
        chkEn = 1'b1;
`endif

        // Randomised traffic with occasional async reset pulses
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                          1'($urandom_range(0, 1)), {$urandom, $urandom});
            if ($urandom_range(0, 149) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
